// File: rtl/fp_accum_ctrl.sv
// Streaming accumulation controller wrapped around the external combinational
// single-precision adder: sums one packet of operands and emits total + beat count.
module fp_accum_ctrl #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic [31:0]        add_dataa,
  output logic [31:0]        add_datab,
  input  logic [31:0]        add_result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               beat_accepted;

  assign beat_accepted = in_valid && in_ready_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; that is what keeps synthesis from inferring a latch.
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (beat_accepted) begin
          acc_d   = in_data;
          count_d = COUNT_ONE;
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat_accepted) begin
          acc_d = add_result;
          if (count_q != COUNT_MAX) count_d = count_q + COUNT_ONE;
          state_d = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags follow the next state, so they flip on the same edge
    // that accepts the last beat or completes the output transfer.
    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign add_dataa = acc_q;
  assign add_datab = in_data;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Bench for fp_accum_ctrl: behavioural float adder around two DUTs (default and
// narrow counter), scoreboard of expected packet results versus observed transfers.
module tb_fp_accum_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_valid2, in_last, out_ready;
  logic [31:0] in_data;

  logic        in_ready, out_valid;
  logic [31:0] out_data, add_dataa, add_datab, add_result;
  logic [7:0]  out_count;

  logic        in_ready2, out_valid2;
  logic [31:0] out_data2, add_dataa2, add_datab2, add_result2;
  logic [1:0]  out_count2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  count;
  } res_t;

  res_t sb[$];
  res_t obs[$];

  function automatic real sp2real(input logic [31:0] f);
    logic [10:0] e;
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  assign add_result  = real2sp(sp2real(add_dataa)  + sp2real(add_datab));
  assign add_result2 = real2sp(sp2real(add_dataa2) + sp2real(add_datab2));

  fp_accum_ctrl #(.COUNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .add_dataa(add_dataa), .add_datab(add_datab), .add_result(add_result)
  );

  fp_accum_ctrl #(.COUNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2),
    .add_dataa(add_dataa2), .add_datab(add_datab2), .add_result(add_result2)
  );

  // A transfer pending at the falling edge completes on the next rising edge.
  always @(negedge clk)
    if (reset_n && out_valid && out_ready) obs.push_back(res_t'({out_data, out_count}));

  task automatic send_beat(input int sel, input logic [31:0] d, input logic last,
                           output int waits);
    waits = 0;
    @(negedge clk);
    in_data = d;
    in_last = last;
    if (sel == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
    while (((sel == 0) ? !in_ready : !in_ready2) && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept: in_ready never rose for beat %h", d);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic check_results(input string name);
    res_t e, o;
    while (sb.size() > 0) begin
      int n = 0;
      while (obs.size() == 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      e = sb.pop_front();
      n_checks++;
      if (obs.size() == 0) begin
        n_fail++;
        $display("FAIL %s_timeout: no result, expected data %h count %0d", name, e.data, e.count);
      end else begin
        o = obs.pop_front();
        if (o.data !== e.data) begin
          n_fail++;
          $display("FAIL %s_data: got %h expected %h", name, o.data, e.data);
        end
        n_checks++;
        if (o.count !== e.count) begin
          n_fail++;
          $display("FAIL %s_count: got %0d expected %0d", name, o.count, e.count);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; in_last = 1'b0;
    in_data = 32'd0; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_data, out_count, in_ready2, out_valid2, out_data2, out_count2} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: rdy %b vld %b data %h cnt %0d (all must be 0)",
                 in_ready, out_valid, out_data, out_count);
      end
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, in_ready2, out_valid2} !== 4'b1010) begin
      n_fail++;
      $display("FAIL ready_after_release: rdy/vld %b%b expected 10", in_ready, out_valid);
    end
  endtask

  task automatic test_two_beat();
    int w;
    out_ready = 1'b1;
    sb.push_back(res_t'({32'h40400000, 8'd2}));
    send_beat(0, 32'h3F800000, 1'b0, w);
    n_checks++;
    if (add_dataa !== 32'h3F800000 || add_datab !== 32'h3F800000) begin
      n_fail++;
      $display("FAIL adder_operands: a %h b %h expected 3f800000 3f800000", add_dataa, add_datab);
    end
    send_beat(0, 32'h40000000, 1'b1, w);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_after_last: vld %b rdy %b expected 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_one_cycle: vld %b rdy %b expected 0 1", out_valid, in_ready);
    end
    check_results("two_beat");
  endtask

  task automatic test_gap();
    int w;
    sb.push_back(res_t'({32'h40E00000, 8'd3}));
    send_beat(0, 32'h3F800000, 1'b0, w);
    send_beat(0, 32'h40000000, 1'b0, w);
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || add_dataa !== 32'h40400000 || out_count !== 8'd2) begin
      n_fail++;
      $display("FAIL gap_hold: vld %b acc %h cnt %0d expected 0 40400000 2",
               out_valid, add_dataa, out_count);
    end
    send_beat(0, 32'h40800000, 1'b1, w);
    check_results("gap");
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    sb.push_back(res_t'({32'h43FA0000, 8'd1}));
    send_beat(0, 32'h43FA0000, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, out_data, out_count} !== {2'b10, 32'h43FA0000, 8'd1}) begin
        n_fail++;
        $display("FAIL hold_%0d: vld %b rdy %b data %h cnt %0d expected 1 0 43fa0000 1",
                 i, out_valid, in_ready, out_data, out_count);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0 || out_count !== 8'd0) begin
      n_fail++;
      $display("FAIL release_idle: vld %b rdy %b data %h cnt %0d expected 0 1 0 0",
               out_valid, in_ready, out_data, out_count);
    end
    check_results("single_beat");
    sb.push_back(res_t'({32'h453DD000, 8'd2}));
    send_beat(0, 32'h41EC0000, 1'b0, w);
    send_beat(0, 32'h453BF800, 1'b1, w);
    check_results("after_release");
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b1;
    sb.push_back(res_t'({32'h40A00000, 8'd2}));
    sb.push_back(res_t'({32'h3F800000, 8'd1}));
    send_beat(0, 32'h40000000, 1'b0, w);
    send_beat(0, 32'h40400000, 1'b1, w);
    send_beat(0, 32'h3F800000, 1'b1, w);
    n_checks++;
    if (w != 1) begin
      n_fail++;
      $display("FAIL b2b_gap: next packet waited %0d cycles expected 1", w);
    end
    check_results("back_to_back");
  endtask

  task automatic test_count_sat();
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(1, 32'h3F800000, i == 4, w);
    n_checks++;
    if ({out_valid2, out_data2, out_count2} !== {1'b1, 32'h40A00000, 2'd3}) begin
      n_fail++;
      $display("FAIL count_sat: vld %b data %h cnt %0d expected 1 40a00000 3",
               out_valid2, out_data2, out_count2);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL count_sat_release: vld %b rdy %b expected 0 1", out_valid2, in_ready2);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bit seen_valid = 0;
    out_ready = 1'b1;
    send_beat(0, 32'h3F800000, 1'b0, w);
    send_beat(0, 32'h40000000, 1'b0, w);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, out_data, out_count} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: vld %b rdy %b data %h cnt %0d expected all 0",
               out_valid, in_ready, out_data, out_count);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    n_checks++;
    if (seen_valid || obs.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_discard: valid seen %0d, %0d results emitted, expected 0 0",
               seen_valid, obs.size());
    end
    sb.push_back(res_t'({32'h40D00000, 8'd2}));
    send_beat(0, 32'h40400000, 1'b0, w);
    send_beat(0, 32'h40600000, 1'b1, w);
    check_results("after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_two_beat();
    test_gap();
    test_backpressure();
    test_back_to_back();
    test_count_sat();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs.size() != 0) begin
      n_fail++;
      $display("FAIL spurious_results: %0d unexpected results, expected 0", obs.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_accum_ctrl.md
# fp_accum_ctrl

Streaming accumulation controller that sits directly around the team's combinational single-precision adder, `ahfp_add`.
- It accepts a packet of IEEE-754 single-precision operands over a valid/ready stream and feeds the running sum and each new operand into the adder.
- It registers the adder's result as the new running sum.
- At end of packet it presents the total and a beat count on an output valid/ready stream.
- The adder itself is instantiated at the parent level. This block owns the sequencing, state and handshakes.

## Interface
- `COUNT_W`, default 8: width of the beat counter. The count saturates at 2^COUNT_W-1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: an operand beat is offered.
- `in_ready`, out, 1: the block can accept a beat. Registered.
- `in_data`, in, 32: operand, single-precision.
- `in_last`, in, 1: marks the final beat of a packet.
- `out_valid`, out, 1: the result is available. Registered.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, 32: packet sum, single-precision.
- `out_count`, out, COUNT_W: number of beats in the packet, saturating.
- `add_dataa`, out, 32: adder operand A, driven from the accumulator register.
- `add_datab`, out, 32: adder operand B, driven combinationally from `in_data`.
- `add_result`, in, 32: combinational adder result, (A+B).

## Operation
- States:
  - IDLE: no packet open.
  - ACCUM: packet open.
  - DONE: result held for downstream.
- A beat is accepted when `in_valid && in_ready` at a rising edge. `in_data` and `in_last` are ignored otherwise.
- IDLE, beat accepted:
  - acc <= `in_data` (direct load, no add), count <= 1.
  - If `in_last`: go to DONE. Otherwise go to ACCUM.
- ACCUM, beat accepted:
  - acc <= `add_result`, count <= count+1, saturating at all-ones.
  - If `in_last`: go to DONE. Otherwise stay in ACCUM.
- ACCUM with no beat: hold acc and count.
- DONE:
  - `out_valid`=1, `out_data`=acc, `out_count`=count. Both outputs are stable while `out_valid && !out_ready`.
  - `in_ready`=0.
  - On `out_ready`, go to IDLE and clear acc to 0 and count to 0.
- Register updates for outputs:
  - `in_ready` is registered. It is 0 in DONE and 1 in IDLE/ACCUM.
  - Accepting an `in_last` beat clears `in_ready` on the same edge.
  - The output handshake sets `in_ready` on the same edge.
  - `out_valid` is set on the edge that accepts `in_last` and cleared on the edge of the output handshake.
- Arithmetic is performed only by the external adder. The block does no rounding, normalisation or special-value handling. Zero, sign and exponent behaviour is whatever `ahfp_add` returns.
- `add_dataa` = acc at all times. `add_datab` = `in_data` at all times. The adder path must settle within one clock period.

## Timing
- Reset (asynchronous, while `reset_n`=0) sets the following:
  - state = IDLE, acc = 0, count = 0.
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `out_count`=0.
- `in_ready` rises on the first rising edge with `reset_n` high.
- Latency: `in_last` is accepted at edge k, and `out_valid`=1 from edge k. The result is therefore visible in the cycle after the last beat.
- Throughput:
  - One beat per cycle inside a packet.
  - At least one cycle in DONE per packet, so a packet of N beats occupies at least N+1 cycles.
- Back-to-back packets: with `out_ready` held at 1, DONE lasts exactly one cycle and the next packet's first beat is accepted at the following edge.
- Single-beat packet (`in_last` on the first beat): `out_data` = that operand bit-exact, `out_count`=1.
- Gaps: `in_valid`=0 mid-packet holds state. There is no timeout.
- Counter: count wraps never. At 2^COUNT_W-1 it holds while acc keeps accumulating.
- Reset asserted mid-packet or in DONE: the packet and any pending result are discarded and nothing is emitted.

## Test plan
- Reset with `reset_n`=0 for 3 cycles -> all outputs 0 during reset; `in_ready`=1 one edge after release; `out_valid` stays 0.
- Packet 3F800000, 40000000 (last), `out_ready`=1 -> `out_data`=40400000, `out_count`=1 then 2 internally, output shows 2; `out_valid` high exactly one cycle, the cycle after the last beat.
- Packet 3F800000, 40000000, 40800000 (last) with `in_valid` dropped for 2 cycles between beats 2 and 3 -> `out_data`=40E00000, `out_count`=3.
- Single beat 43FA0000 with `in_last`, `out_ready`=0 for 4 cycles -> `out_valid`=1, `out_data`=43FA0000 held stable, `in_ready`=0 throughout; released by `out_ready`=1 and returns to IDLE; next packet 41EC0000, 453BF800 -> 453DD000.
- `COUNT_W`=2, packet of five 3F800000 beats -> `out_data`=40A00000, `out_count`=3 (saturated).
- Reset pulse after the second beat of a 4-beat packet -> no `out_valid`; a subsequent packet 40400000, 40600000 -> 40D00000, count 2.
